apb_regfile_slave: RTL and testbench

Parametrised APB4 completer that fronts a bank of memory-mapped registers for the APB testbench DUT side. It generalises the existing single-width APB signalling with configurable data/address width, register count, programmable wait states, byte strobes, read-only registers and PSLVERR error signalling. It sits behind one PSEL line of the APB requester and exposes register contents and status inputs to surrounding hardware.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_wait_ctr.sv | 28 ++
 rtl/apb_regfile_slave.sv | 168 ++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state type, counter width and strobe helper for the APB register-file completer
package apb_pkg;

  // Transfer progress as seen by the completer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

  // Wide enough for up to 15 programmed wait states
  localparam int WAIT_W = 4;

  // Number of byte lanes for a given data width
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// rtl/apb_wait_ctr.sv - loadable down-counter that paces the access phase
module apb_wait_ctr
  import apb_pkg::*;
(
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_cnt;

  // Load wins over decrement so every fresh setup restarts the count; saturate at zero
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB4 completer fronting a bank of byte-strobed, optionally read-only registers
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int                  ADDR_W      = 32,
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [strb_w(DATA_W)-1:0]    pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status
);

  localparam int BYTES   = strb_w(DATA_W);
  localparam int ALIGN_W = $clog2(BYTES);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] REG_LIMIT  = ADDR_W'(NUM_REGS);
  // Counter is loaded one short because the WAIT cycle that sees zero is itself a wait cycle
  localparam logic [WAIT_W-1:0] LOAD_VAL   = (WAIT_STATES > 0) ? WAIT_W'(WAIT_STATES - 1) : '0;
  localparam apb_state_e        AFTER_SETUP = (WAIT_STATES == 0) ? DONE : WAIT;

  apb_state_e r_state;
  apb_state_e w_next;

  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic              r_err;
  logic              r_ro;
  logic [DATA_W-1:0] r_wdata;
  logic [BYTES-1:0]  r_strb;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_setup;
  logic              w_commit;
  logic              w_dec;
  logic              w_zero;
  logic [ADDR_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_aligned;
  logic              w_ro_sel;
  logic              w_err;
  logic [DATA_W-1:0] w_hw [NUM_REGS];
  logic [DATA_W-1:0] w_rd_val;

  // Address decode and error classification happen on the setup cycle only
  assign w_setup    = psel & ~penable;
  assign w_idx_full = paddr >> ALIGN_W;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_in_range = (w_idx_full < REG_LIMIT);
  assign w_aligned  = ((paddr & ALIGN_MASK) == '0);
  assign w_ro_sel   = w_in_range & RO_MASK[w_idx];
  assign w_err      = ~w_in_range | ~w_aligned | (pwrite & w_ro_sel);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign reg_q[i*DATA_W +: DATA_W] = r_regs[i];
    assign w_hw[i]                   = hw_status[i*DATA_W +: DATA_W];
  end

  // Read-only registers reflect live hardware status instead of stored contents
  assign w_rd_val = r_ro ? w_hw[r_idx] : r_regs[r_idx];

  apb_wait_ctr u_wait_ctr (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .i_load     (w_setup),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: setup restarts from any state, a dropped psel abandons the transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_setup) w_next = AFTER_SETUP;
      end
      WAIT: begin
        if (!psel)         w_next = IDLE;
        else if (!penable) w_next = AFTER_SETUP;
        else if (w_zero)   w_next = DONE;
      end
      DONE: begin
        if (!psel)         w_next = IDLE;
        else if (!penable) w_next = AFTER_SETUP;
        else               w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs: bus response only in DONE, write commit on the completing access edge
  always_comb begin
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    w_commit = 1'b0;
    w_dec    = 1'b0;
    case (r_state)
      WAIT: begin
        w_dec = psel & penable;
      end
      DONE: begin
        pready   = 1'b1;
        pslverr  = r_err;
        prdata   = r_err ? '0 : w_rd_val;
        w_commit = psel & penable & r_write & ~r_err;
      end
      default: begin
      end
    endcase
  end

  // Capture the transfer attributes on every sampled setup
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_idx   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_ro    <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
    end else if (w_setup) begin
      r_idx   <= w_idx;
      r_write <= pwrite;
      r_err   <= w_err;
      r_ro    <= w_ro_sel;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  end

  // Register bank: byte lanes with a clear strobe keep their old value
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_strb[b]) r_regs[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - randomized model-checked bench for apb_regfile_slave
module tb_apb_regfile_slave;

  localparam int         NR  = 8;
  localparam int         WS0 = 0;
  localparam int         WS1 = 3;
  localparam logic [7:0] RO0 = 8'h01;
  localparam logic [7:0] RO1 = 8'h84;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         psel_v    [2];
  logic         penable_v [2];
  logic         pwrite_v  [2];
  logic [31:0]  paddr_v   [2];
  logic [31:0]  pwdata_v  [2];
  logic [3:0]   pstrb_v   [2];
  logic [31:0]  prdata_v  [2];
  logic         pready_v  [2];
  logic         pslverr_v [2];
  logic [255:0] regq_v    [2];
  logic [255:0] hw_v      [2];

  apb_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(WS0), .RO_MASK(RO0)) dut0 (
    .pclk(clk), .preset_n(rst_n), .psel(psel_v[0]), .penable(penable_v[0]), .pwrite(pwrite_v[0]),
    .paddr(paddr_v[0]), .pwdata(pwdata_v[0]), .pstrb(pstrb_v[0]), .prdata(prdata_v[0]),
    .pready(pready_v[0]), .pslverr(pslverr_v[0]), .reg_q(regq_v[0]), .hw_status(hw_v[0])
  );

  apb_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .WAIT_STATES(WS1), .RO_MASK(RO1)) dut1 (
    .pclk(clk), .preset_n(rst_n), .psel(psel_v[1]), .penable(penable_v[1]), .pwrite(pwrite_v[1]),
    .paddr(paddr_v[1]), .pwdata(pwdata_v[1]), .pstrb(pstrb_v[1]), .prdata(prdata_v[1]),
    .pready(pready_v[1]), .pslverr(pslverr_v[1]), .reg_q(regq_v[1]), .hw_status(hw_v[1])
  );

  // Reference state: register contents and the response expected in the current cycle
  logic [31:0] m_regs [2][NR];
  logic        exp_pready  [2];
  logic        exp_pslverr [2];
  logic [31:0] exp_prdata  [2];
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input int d, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Every cycle: both completers must show exactly the modelled response and register image
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [255:0] eq;
        for (int i = 0; i < NR; i++) eq[i*32 +: 32] = m_regs[d][i];
        chk("pready",  d, 256'(pready_v[d]),  256'(exp_pready[d]));
        chk("pslverr", d, 256'(pslverr_v[d]), 256'(exp_pslverr[d]));
        chk("prdata",  d, 256'(prdata_v[d]),  256'(exp_prdata[d]));
        chk("reg_q",   d, regq_v[d], eq);
      end
    end
  end

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) m_regs[d][i] = 32'h0;
  endtask

  task automatic clear_exp(input int d);
    exp_pready[d]  = 1'b0;
    exp_pslverr[d] = 1'b0;
    exp_prdata[d]  = 32'h0;
  endtask

  task automatic bus_idle(input int d);
    psel_v[d]    = 1'b0;
    penable_v[d] = 1'b0;
  endtask

  // One transfer starting right now (just after a rising edge).
  // mode 0 normal, 1 drop psel at access cycle 'at', 2 re-setup as a read at 'at', 3 reset at 'at'
  task automatic xfer(input int d, input bit wr_in, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int mode_in, input int at,
                      output logic [31:0] rdata, output logic rerr);
    int         ws;
    int         idx;
    int         mode;
    bit         wr;
    bit         ro;
    bit         err;
    logic [7:0] msk;
    ws    = (d == 0) ? WS0 : WS1;
    msk   = (d == 0) ? RO0 : RO1;
    mode  = mode_in;
    wr    = wr_in;
    rdata = 32'h0;
    rerr  = 1'b0;
    idx   = int'(addr >> 2);
    ro    = (idx < NR) ? msk[idx] : 1'b0;
    err   = (idx >= NR) || (addr[1:0] != 2'b00) || (wr && ro);
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
    paddr_v[d] = addr; pwdata_v[d] = data; pstrb_v[d] = strb;
    @(posedge clk); #1;
    penable_v[d] = 1'b1;
    for (int k = 1; k <= ws + 1; k++) begin
      if (mode != 0 && k == at) begin
        if (mode == 1) begin
          bus_idle(d);
          @(posedge clk); #1;
          return;
        end
        if (mode == 3) begin
          rst_n = 1'b0;
          bus_idle(d);
          clear_model();
          @(posedge clk);
          @(posedge clk); #1;
          rst_n = 1'b1;
          return;
        end
        penable_v[d] = 1'b0;
        pwrite_v[d]  = 1'b0;
        wr   = 1'b0;
        err  = (idx >= NR) || (addr[1:0] != 2'b00);
        mode = 0;
        @(posedge clk); #1;
        penable_v[d] = 1'b1;
        k = 0;
        continue;
      end
      if (k == ws + 1) begin
        exp_pready[d]  = 1'b1;
        exp_pslverr[d] = err;
        exp_prdata[d]  = err ? 32'h0 : (ro ? hw_v[d][idx*32 +: 32] : m_regs[d][idx]);
        @(negedge clk);
        rdata = prdata_v[d];
        rerr  = pslverr_v[d];
      end
      @(posedge clk); #1;
    end
    if (wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[d][idx][b*8 +: 8] = data[b*8 +: 8];
    end
    clear_exp(d);
    bus_idle(d);
  endtask

  logic [31:0] rd;
  logic        re;

  initial begin
    for (int d = 0; d < 2; d++) begin
      bus_idle(d);
      pwrite_v[d] = 1'b0; paddr_v[d] = 32'h0; pwdata_v[d] = 32'h0; pstrb_v[d] = 4'h0;
      clear_exp(d);
      for (int i = 0; i < NR; i++) hw_v[d][i*32 +: 32] = $urandom;
    end
    hw_v[0][31:0] = 32'h5A5A5A5A;
    clear_model();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regq0", 0, regq_v[0], 256'h0);
    chk("reset_pready1", 1, 256'(pready_v[1]), 256'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain write then read back with zero wait states
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, rd, re);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 0, 0, rd, re);
    chk("rd_deadbeef", 0, 256'(rd), 256'h0DEADBEEF);
    chk("rd_deadbeef_err", 0, 256'(re), 256'h0);
    chk("model_pin_reg1", 0, 256'(m_regs[0][1]), 256'h0DEADBEEF);

    // Three wait states: read of a fresh register returns zero on the 4th access cycle
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 0, 0, rd, re);
    chk("rd_ws3_zero", 1, 256'(rd), 256'h0);

    // Partial strobes merge into the held value
    xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 0, 0, rd, re);
    xfer(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 0, 0, rd, re);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, rd, re);
    chk("rd_strb_merge", 0, 256'(rd), 256'h0AA22CC44);

    // Out-of-range and unaligned accesses error without side effects
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, re);
    chk("oor_err", 0, 256'(re), 256'h1);
    chk("oor_rdata", 0, 256'(rd), 256'h0);
    xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 0, 0, rd, re);
    chk("unaligned_err", 0, 256'(re), 256'h1);

    // Read-only register: write rejected, read returns live status
    xfer(0, 1'b1, 32'h00, 32'h0, 4'hF, 0, 0, rd, re);
    chk("ro_write_err", 0, 256'(re), 256'h1);
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, 0, rd, re);
    chk("ro_read_val", 0, 256'(rd), 256'h05A5A5A5A);
    chk("ro_read_err", 0, 256'(re), 256'h0);

    // Aborted write, restarted write, then reset in the middle of a transfer
    xfer(1, 1'b1, 32'h0C, 32'h12345678, 4'hF, 1, 2, rd, re);
    xfer(1, 1'b1, 32'h0C, 32'h12345678, 4'hF, 2, 1, rd, re);
    xfer(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 0, rd, re);
    xfer(1, 1'b1, 32'h14, 32'h87654321, 4'hF, 3, 2, rd, re);
    chk("post_reset_regq1", 1, regq_v[1], 256'h0);
    chk("post_reset_regq0", 0, regq_v[0], 256'h0);

    // Randomized traffic on both completers
    for (int n = 0; n < 250; n++) begin
      int          d;
      int          mode;
      int          at;
      logic [31:0] addr;
      d    = int'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 9)) * 32'd4;
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      mode = 0;
      at   = 0;
      if (d == 1) begin
        at = int'($urandom_range(1, WS1));
        case ($urandom_range(0, 29))
          0, 1, 2: mode = 1;
          3, 4, 5: mode = 2;
          6:       mode = 3;
          default: mode = 0;
        endcase
      end
      if ($urandom_range(0, 9) == 0) hw_v[d][$urandom_range(0, NR-1)*32 +: 32] = $urandom;
      xfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), mode, at, rd, re);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
